// File: rtl/dms_pkg.sv
// Shared types and defaults for the DMS serial encoder.
// Holds the FSM state enum, timing defaults and size limits.
package dms_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_N,
        S_CFG_D,
        S_CFG_C,
        S_DATA_HI,
        S_DATA_LO,
        S_TERM,
        S_TAIL
    } state_t;

    localparam int DEF_BIT_PERIOD = 8;
    localparam int DEF_ONES_1     = 6;
    localparam int DEF_ONES_0     = 2;
    localparam int DEF_TAIL       = 64;
    localparam int MAX_N          = 5;
    localparam int MAX_LEN        = 16;

    // Key and caps frames are 2^n bits wide.
    function automatic logic [5:0] key_len(input logic [3:0] n);
        return 6'd1 << n;
    endfunction

endpackage

// File: rtl/dms_piso.sv
// 32-bit parallel-load, MSB-first shift register.
// A load left-aligns the low len_i bits so bit_o is the first bit to send.
module dms_piso (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        shift_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  len_i,
    output logic        bit_o,
    output logic        last_o
);

    logic [31:0] sh_q, sh_d;
    logic [5:0]  cnt_q, cnt_d;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sh_d  = data_i << (6'd32 - len_i);
            cnt_d = len_i;
        end else if (shift_i && cnt_q != 6'd0) begin
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign bit_o  = sh_q[31];
    assign last_o = (cnt_q == 6'd1);

endmodule

// File: rtl/dms_encoder.sv
// DMS line encoder: optional config frame (n, d, caps) then
// pulse-width coded message bits, a terminator pulse and a low tail.
module dms_encoder
    import dms_pkg::*;
#(
    parameter int BIT_PERIOD = DEF_BIT_PERIOD,
    parameter int ONES_1     = DEF_ONES_1,
    parameter int ONES_0     = DEF_ONES_0,
    parameter int TAIL       = DEF_TAIL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cfg_en,
    input  logic [3:0]  cfg_n,
    input  logic [31:0] cfg_d,
    input  logic [31:0] cfg_caps,
    input  logic [15:0] msg_in,
    input  logic [4:0]  msg_len,
    output logic        str,
    output logic        mode,
    output logic        ready,
    output logic        done,
    output logic        err
);

    state_t      state_q, state_d;
    logic [15:0] cyc_q, cyc_d;
    logic [3:0]  n_q, n_d;
    logic [31:0] d_q, d_d;
    logic [31:0] caps_q, caps_d;
    logic [15:0] msg_q, msg_d;
    logic [4:0]  len_q, len_d;
    logic        cfgd_q, cfgd_d;
    logic        err_q, err_d;

    logic        ld;
    logic        sh;
    logic [31:0] ld_data;
    logic [5:0]  ld_len;
    logic        pbit;
    logic        plast;
    logic        reject;
    logic [15:0] hi_last;

    dms_piso u_piso (
        .clk    (clk),
        .reset  (reset),
        .load_i (ld),
        .shift_i(sh),
        .data_i (ld_data),
        .len_i  (ld_len),
        .bit_o  (pbit),
        .last_o (plast)
    );

    assign reject = (cfg_en && cfg_n > 4'(MAX_N))
                 || (msg_len == 5'd0)
                 || (msg_len > 5'(MAX_LEN))
                 || (!cfg_en && !cfgd_q);

    assign hi_last = pbit ? 16'(ONES_1 - 1) : 16'(ONES_0 - 1);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        n_d     = n_q;
        d_d     = d_q;
        caps_d  = caps_q;
        msg_d   = msg_q;
        len_d   = len_q;
        cfgd_d  = cfgd_q;
        err_d   = 1'b0;
        ld      = 1'b0;
        sh      = 1'b0;
        ld_data = '0;
        ld_len  = '0;
        str     = 1'b0;
        mode    = 1'b0;
        ready   = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        n_d    = cfg_n;
                        d_d    = cfg_d;
                        caps_d = cfg_caps;
                        msg_d  = msg_in;
                        len_d  = msg_len;
                        cyc_d  = '0;
                        ld     = 1'b1;
                        if (cfg_en) begin
                            ld_data = {28'd0, cfg_n};
                            ld_len  = 6'd4;
                            state_d = S_CFG_N;
                        end else begin
                            ld_data = {16'd0, msg_in};
                            ld_len  = {1'b0, msg_len};
                            state_d = S_DATA_HI;
                        end
                    end
                end
            end

            S_CFG_N: begin
                mode = 1'b1;
                str  = pbit;
                if (plast) begin
                    ld      = 1'b1;
                    ld_data = d_q;
                    ld_len  = key_len(n_q);
                    state_d = S_CFG_D;
                end else begin
                    sh = 1'b1;
                end
            end

            S_CFG_D: begin
                mode = 1'b1;
                str  = pbit;
                if (plast) begin
                    ld      = 1'b1;
                    ld_data = caps_q;
                    ld_len  = key_len(n_q);
                    state_d = S_CFG_C;
                end else begin
                    sh = 1'b1;
                end
            end

            S_CFG_C: begin
                mode = 1'b1;
                str  = pbit;
                if (plast) begin
                    ld      = 1'b1;
                    ld_data = {16'd0, msg_q};
                    ld_len  = {1'b0, len_q};
                    cfgd_d  = 1'b1;
                    cyc_d   = '0;
                    state_d = S_DATA_HI;
                end else begin
                    sh = 1'b1;
                end
            end

            // cyc_q runs across HI and LO so each bit spans BIT_PERIOD.
            S_DATA_HI: begin
                str   = 1'b1;
                cyc_d = cyc_q + 16'd1;
                if (cyc_q == hi_last) begin
                    state_d = S_DATA_LO;
                end
            end

            S_DATA_LO: begin
                if (cyc_q == 16'(BIT_PERIOD - 1)) begin
                    cyc_d = '0;
                    if (plast) begin
                        state_d = S_TERM;
                    end else begin
                        sh      = 1'b1;
                        state_d = S_DATA_HI;
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end

            S_TERM: begin
                str     = 1'b1;
                cyc_d   = '0;
                state_d = S_TAIL;
            end

            S_TAIL: begin
                if (cyc_q == 16'(TAIL - 1)) begin
                    done    = 1'b1;
                    cyc_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            n_q     <= '0;
            d_q     <= '0;
            caps_q  <= '0;
            msg_q   <= '0;
            len_q   <= '0;
            cfgd_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            n_q     <= n_d;
            d_q     <= d_d;
            caps_q  <= caps_d;
            msg_q   <= msg_d;
            len_q   <= len_d;
            cfgd_q  <= cfgd_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_dms_encoder.sv
// Table-driven bench for dms_encoder with a per-cycle
// expected-waveform scoreboard.
module tb_dms_encoder;

    localparam int BP = 8;
    localparam int O1 = 6;
    localparam int O0 = 2;
    localparam int TL = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cfg_en;
    logic [3:0]  cfg_n;
    logic [31:0] cfg_d;
    logic [31:0] cfg_caps;
    logic [15:0] msg_in;
    logic [4:0]  msg_len;
    logic        str;
    logic        mode;
    logic        ready;
    logic        done;
    logic        err;

    dms_encoder dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cfg_en  (cfg_en),
        .cfg_n   (cfg_n),
        .cfg_d   (cfg_d),
        .cfg_caps(cfg_caps),
        .msg_in  (msg_in),
        .msg_len (msg_len),
        .str     (str),
        .mode    (mode),
        .ready   (ready),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cfg_en;
        logic [3:0]  n;
        logic [31:0] d;
        logic [31:0] caps;
        logic [15:0] msg;
        logic [4:0]  len;
        logic        exp_err;
    } vec_t;

    // {str, mode, ready, done, err}
    typedef logic [4:0] obs_t;

    obs_t q[$];
    int   pass_cnt = 0;
    int   total    = 0;

    function automatic obs_t sample();
        return {str, mode, ready, done, err};
    endfunction

    task automatic check(input string nm, input int idx,
                         input obs_t act, input obs_t exp);
        total++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s[%0d]: got {str,mode,ready,done,err}=%b want %b",
                     nm, idx, act, exp);
        end
    endtask

    task automatic expect_cmd(input vec_t v);
        int kl;
        int ones;
        if (v.exp_err) begin
            q.push_back(5'b00101);
            q.push_back(5'b00100);
            return;
        end
        if (v.cfg_en) begin
            for (int i = 3; i >= 0; i--)
                q.push_back({v.n[i], 4'b1000});
            kl = 1 << v.n;
            for (int i = kl - 1; i >= 0; i--)
                q.push_back({v.d[i], 4'b1000});
            for (int i = kl - 1; i >= 0; i--)
                q.push_back({v.caps[i], 4'b1000});
        end
        for (int i = int'(v.len) - 1; i >= 0; i--) begin
            ones = v.msg[i] ? O1 : O0;
            for (int k = 0; k < BP; k++)
                q.push_back({(k < ones), 4'b0000});
        end
        q.push_back(5'b10000);
        for (int t = 0; t < TL; t++)
            q.push_back({3'b000, (t == TL - 1), 1'b0});
        q.push_back(5'b00100);
    endtask

    task automatic drive(input vec_t v);
        cfg_en   = v.cfg_en;
        cfg_n    = v.n;
        cfg_d    = v.d;
        cfg_caps = v.caps;
        msg_in   = v.msg;
        msg_len  = v.len;
        start    = 1'b1;
    endtask

    // poke >= 0 raises an illegal start while the encoder is busy.
    task automatic run(input vec_t v, input string nm, input int poke);
        obs_t e;
        int   idx;
        expect_cmd(v);
        drive(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        idx   = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            check(nm, idx, sample(), e);
            if (idx == poke) begin
                start  = 1'b1;
                cfg_en = 1'b1;
                cfg_n  = 4'd6;
            end else begin
                start = 1'b0;
            end
            idx++;
            if (q.size() > 0) begin
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b0, 4'd0, 32'h0,        32'h0,        16'h0005, 5'd3,  1'b1};
        tbl[1]  = '{1'b1, 4'd2, 32'hA,        32'h1,        16'h0005, 5'd3,  1'b0};
        tbl[2]  = '{1'b0, 4'd0, 32'h0,        32'h0,        16'h0005, 5'd3,  1'b0};
        tbl[3]  = '{1'b1, 4'd6, 32'hF,        32'hF,        16'h0005, 5'd3,  1'b1};
        tbl[4]  = '{1'b0, 4'd0, 32'h0,        32'h0,        16'h0005, 5'd0,  1'b1};
        tbl[5]  = '{1'b0, 4'd0, 32'h0,        32'h0,        16'h0005, 5'd17, 1'b1};
        tbl[6]  = '{1'b1, 4'd0, 32'h1,        32'h0,        16'h0001, 5'd1,  1'b0};
        tbl[7]  = '{1'b1, 4'd5, 32'hDEADBEEF, 32'h0F0F00F0, 16'hA5C3, 5'd16, 1'b0};
        tbl[8]  = '{1'b0, 4'd0, 32'h0,        32'h0,        16'hFFFF, 5'd16, 1'b0};
        tbl[9]  = '{1'b0, 4'd0, 32'h0,        32'h0,        16'h0000, 5'd1,  1'b0};
        tbl[10] = '{1'b1, 4'd3, 32'h5A,       32'h81,       16'h0000, 5'd0,  1'b1};

        reset    = 1'b1;
        start    = 1'b0;
        cfg_en   = 1'b0;
        cfg_n    = '0;
        cfg_d    = '0;
        cfg_caps = '0;
        msg_in   = '0;
        msg_len  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, sample(), 5'b00100);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle", 0, sample(), 5'b00100);

        for (int i = 0; i < 11; i++)
            run(tbl[i], $sformatf("vec%0d", i), (i == 2) ? 30 : -1);

        // Reset while the key frame is being sent.
        drive(tbl[1]);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("in_cfg_d", 0, sample(), {tbl[1].d[2], 4'b1000});
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_reset", 0, sample(), 5'b00100);
        @(posedge clk);
        #1;
        check("post_reset", 0, sample(), 5'b00100);
        run(tbl[0], "unconf_after_reset", -1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
